// File: rtl/map_row_cache.sv
// Double-buffered map row cache: prefetches the next line's map row in hblank.
// Define MAP_ROW_CACHE_STATS_EN to add the o_miss_count statistics output.
module map_row_cache #(
  parameter int H_VIEW    = 640,
  parameter int V_TOTAL   = 525,
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4,
  parameter int MAP_SCALE = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  output logic                 o_rom_req,
  input  logic                 i_rom_gnt,
  output logic [MAP_WBITS-1:0] o_rom_col,
  output logic [MAP_HBITS-1:0] o_rom_row,
  input  logic [1:0]           i_rom_val,
  input  logic [MAP_WBITS-1:0] i_ovl_col,
  output logic [1:0]           o_map_val,
`ifdef MAP_ROW_CACHE_STATS_EN
  output logic [7:0]           o_miss_count,
`endif
  output logic                 o_valid
);

  localparam int MAP_WIDTH  = 1 << MAP_WBITS;
  localparam int MAP_HEIGHT = 1 << MAP_HBITS;
  localparam int MAP_LINES  = MAP_HEIGHT << MAP_SCALE;
  localparam int ROW_LO     = MAP_SCALE;
  localparam int ROW_HI     = MAP_SCALE + MAP_HBITS - 1;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [MAP_WBITS-1:0] col;
  logic [MAP_WBITS-1:0] col_nxt;

  logic [MAP_WIDTH-1:0][1:0] front;
  logic [MAP_WIDTH-1:0][1:0] back;
  logic [MAP_HBITS-1:0]      front_row;
  logic [MAP_HBITS-1:0]      back_row;
  logic                      front_valid;
  logic                      back_full;

  logic [9:0]           next_line;
  logic [MAP_HBITS-1:0] tgt_row;
  logic [MAP_HBITS-1:0] cur_row;
  logic                 next_in_map;
  logic                 cur_in_map;
  logic                 trig;
  logic                 need;
  logic                 swap;
  logic                 capture;
  logic                 last;
  logic                 start;

  assign next_line   = (vpos == 10'(V_TOTAL - 1)) ? '0 : vpos + 10'd1;
  assign tgt_row     = next_line[ROW_HI:ROW_LO];
  assign cur_row     = vpos[ROW_HI:ROW_LO];
  assign next_in_map = next_line < 10'(MAP_LINES);
  assign cur_in_map  = vpos < 10'(MAP_LINES);
  assign trig        = hpos == 10'(H_VIEW);

  assign need = next_in_map
             && (tgt_row != front_row || !front_valid)
             && (tgt_row != back_row  || !back_full);

  assign swap    = (hpos == '0) && back_full;
  // A trigger restarts the fill, so its cycle never captures.
  assign capture = (state == FILL) && i_rom_gnt && !trig;
  assign last    = capture && (col == MAP_WBITS'(MAP_WIDTH - 1));

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    start     = 1'b0;
    unique case (1'b1)
      trig: begin
        if (need) begin
          state_nxt = FILL;
          col_nxt   = '0;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      capture: begin
        col_nxt = col + 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      col   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front       <= '0;
      back        <= '0;
      front_row   <= '0;
      back_row    <= '0;
      front_valid <= 1'b0;
      back_full   <= 1'b0;
    end else begin
      if (capture) back[col] <= i_rom_val;
      if (start) begin
        back_row  <= tgt_row;
        back_full <= 1'b0;
      end else if (last) begin
        back_full <= 1'b1;
      end
      if (swap) begin
        front       <= back;
        front_row   <= back_row;
        front_valid <= 1'b1;
        back_full   <= 1'b0;
      end
    end
  end

  assign o_rom_req = state == FILL;
  assign o_rom_col = col;
  assign o_rom_row = back_row;

  assign o_valid   = front_valid && (front_row == cur_row) && cur_in_map;
  assign o_map_val = o_valid ? front[i_ovl_col] : 2'b00;

`ifdef MAP_ROW_CACHE_STATS_EN
  logic valid_after;
  logic miss;

  // Validity as seen by the line starting now, including this cycle's swap.
  assign valid_after = swap ? (back_row == cur_row)
                            : (front_valid && front_row == cur_row);
  assign miss = (hpos == '0) && cur_in_map && !valid_after;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_miss_count <= '0;
    end else if (hpos == '0 && vpos == '0) begin
      o_miss_count <= '0;
    end else if (miss && o_miss_count != 8'hFF) begin
      o_miss_count <= o_miss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_map_row_cache.sv
// Scoreboard bench for map_row_cache: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_map_row_cache;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       o_rom_req;
  logic       i_rom_gnt = 1'b0;
  logic [3:0] o_rom_col;
  logic [3:0] o_rom_row;
  logic [1:0] i_rom_val;
  logic [3:0] i_ovl_col = '0;
  logic [1:0] o_map_val;
  logic       o_valid;
`ifdef MAP_ROW_CACHE_STATS_EN
  logic [7:0] o_miss_count;
`endif

  always #5 clk = ~clk;

  map_row_cache dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .o_rom_req (o_rom_req),
    .i_rom_gnt (i_rom_gnt),
    .o_rom_col (o_rom_col),
    .o_rom_row (o_rom_row),
    .i_rom_val (i_rom_val),
    .i_ovl_col (i_ovl_col),
    .o_map_val (o_map_val),
`ifdef MAP_ROW_CACHE_STATS_EN
    .o_miss_count (o_miss_count),
`endif
    .o_valid   (o_valid)
  );

  logic [1:0] rom [16][16];
  assign i_rom_val = rom[o_rom_row][o_rom_col];

  typedef struct packed {
    logic       req;
    logic [3:0] row;
    logic [3:0] col;
    logic       valid;
    logic [1:0] val;
    logic [7:0] miss;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: which row is being fetched and how far, which rows
  // sit in the back and front buffers.
  bit m_fill;
  int m_row;
  int m_cnt;
  bit m_bfull;
  int m_brow;
  bit m_fvalid;
  int m_frow;
  int m_miss;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rom_req", int'(o_rom_req), int'(e.req));
      if (e.req) begin
        check("rom_row", int'(o_rom_row), int'(e.row));
        check("rom_col", int'(o_rom_col), int'(e.col));
      end
      check("valid", int'(o_valid), int'(e.valid));
      check("map_val", int'(o_map_val), int'(e.val));
`ifdef MAP_ROW_CACHE_STATS_EN
      check("miss_count", int'(o_miss_count), int'(e.miss));
`endif
    end
  end

  task automatic model_reset();
    m_fill = 0; m_row = 0; m_cnt = 0;
    m_bfull = 0; m_brow = 0;
    m_fvalid = 0; m_frow = 0; m_miss = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int   h, v, vrow, nl, tr;
    bit   need;
    h = int'(hpos);
    v = int'(vpos);
    if (!reset_n) model_reset();
    vrow = (v / 8) % 16;
    e.req   = m_fill;
    e.row   = 4'(m_brow);
    e.col   = 4'(m_cnt);
    e.valid = m_fvalid && m_frow == vrow && v < 128;
    e.val   = e.valid ? rom[m_frow][i_ovl_col] : 2'b00;
    e.miss  = 8'(m_miss);
    q.push_back(e);
    if (!reset_n) return;
    if (h == 0) begin
      if (m_bfull) begin
        m_fvalid = 1; m_frow = m_brow; m_bfull = 0;
      end
      if (v == 0) m_miss = 0;
      else if (v < 128 && !(m_fvalid && m_frow == vrow) && m_miss < 255)
        m_miss++;
    end
    if (h == 640) begin
      nl = (v == 524) ? 0 : v + 1;
      tr = (nl / 8) % 16;
      need = nl < 128 && (!m_fvalid || tr != m_frow)
                      && (!m_bfull || tr != m_brow);
      if (need) begin
        m_fill = 1; m_cnt = 0; m_brow = tr; m_bfull = 0;
      end else begin
        m_fill = 0;
      end
    end else if (m_fill && i_rom_gnt) begin
      m_cnt++;
      if (m_cnt == 16) begin
        m_fill = 0; m_bfull = 1;
      end
    end
  endtask

  task automatic cyc(int h, int v, bit g, bit r);
    @(posedge clk);
    #1;
    reset_n   = r;
    hpos      = 10'(h);
    vpos      = 10'(v);
    i_rom_gnt = g;
    i_ovl_col = 4'($urandom_range(0, 15));
    model_step();
  endtask

  function automatic bit gbit(int mode, int k);
    case (mode)
      0:       return $urandom_range(0, 3) != 0;
      1:       return 1'b1;
      2:       return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  // One compressed video line: hpos 0.. then the hblank run from H_VIEW.
  task automatic line(int v, int act, int blank, int amode, int bmode);
    for (int k = 0; k < act; k++) cyc(k, v, gbit(amode, k), 1'b1);
    for (int k = 0; k < blank; k++) cyc(640 + k, v, gbit(bmode, k), 1'b1);
  endtask

  initial begin
    int v, r, mode;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        rom[i][j] = 2'($urandom_range(0, 3));
    model_reset();

    for (int k = 0; k < 3; k++) cyc(0, 0, 1'b0, 1'b0);

    // constant grant: rows 0 and 1, then a same-row line
    line(6, 4, 20, 1, 1);
    line(7, 4, 20, 1, 1);
    line(8, 6, 20, 1, 1);
    line(9, 6, 20, 1, 1);
    line(10, 4, 4, 1, 1);

    // alternating grant
    line(15, 4, 36, 2, 2);
    line(16, 20, 4, 0, 0);

    // grant withheld until the next line starts
    line(23, 4, 20, 3, 3);
    line(24, 20, 20, 1, 1);
    line(25, 6, 4, 1, 1);

    // frame wrap and out-of-map next line
    line(524, 4, 20, 1, 1);
    line(0, 6, 4, 1, 1);
    line(200, 4, 20, 1, 1);

    // reset in the middle of a fill at col 9
    line(30, 4, 10, 1, 1);
    cyc(650, 30, 1'b1, 1'b0);
    cyc(651, 30, 1'b1, 1'b0);
    line(31, 4, 20, 1, 1);
    line(32, 6, 4, 0, 0);

    v = 40;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 140);
      else if ($urandom_range(0, 29) == 0) v = $urandom_range(0, 524);
      else v = (v == 524) ? 0 : v + 1;
      r = $urandom_range(0, 9);
      mode = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      line(v, $urandom_range(1, 30), $urandom_range(2, 40),
           $urandom_range(0, 2), mode);
      if ($urandom_range(0, 99) == 0) cyc(0, v, 1'b0, 1'b0);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/map_row_cache.md
Name: map_row_cache

Overview:
- Sits directly upstream of the map overlay renderer.
- Prefetches one map row (MAP_WIDTH cells × 2 bits) from the shared map ROM during horizontal blanking, using a request/grant port; the tracer keeps priority over that port.
- Serves cell values to the overlay from a double-buffered row register, so the overlay no longer touches the map ROM during active video.

Parameters:
- H_VIEW, 640, first hblank hpos; fetch trigger point.
- V_TOTAL, 525, total lines per frame; used for the next-line wrap.
- MAP_WBITS, 4, log2 of map width in cells.
- MAP_HBITS, 4, log2 of map height in cells.
- MAP_SCALE, 3, log2 of pixels per map cell in the overlay.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hpos  in  10  current pixel column
- vpos  in  10  current line
- o_rom_req  out  1  map ROM access request
- i_rom_gnt  in  1  grant; i_rom_val is valid in the same cycle when high
- o_rom_col  out  MAP_WBITS  ROM column address
- o_rom_row  out  MAP_HBITS  ROM row address
- i_rom_val  in  2  ROM cell value (combinational ROM)
- i_ovl_col  in  MAP_WBITS  overlay's requested column
- o_map_val  out  2  cell value for i_ovl_col from the front buffer; 0 if invalid
- o_valid  out  1  front buffer holds the current line's map row

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; fill column counter=0.
  - front/back buffers=0; front_row=0; back_row=0; front_valid=0; back_full=0.
  - Outputs: o_rom_req=0, o_rom_col=0, o_rom_row=0, o_map_val=0, o_valid=0.
- next_line = (vpos==V_TOTAL-1) ? 0 : vpos+1.
- tgt_row = next_line[MAP_SCALE+MAP_HBITS-1:MAP_SCALE].
- in_map(next_line) = next_line < (MAP_HEIGHT<<MAP_SCALE).
- Trigger: the cycle where hpos==H_VIEW. A fill starts only if all of these hold:
  - in_map(next_line);
  - tgt_row != front_row or front_valid==0;
  - tgt_row != back_row or back_full==0.
  - On start: state=FILL, col=0, back_row=tgt_row, back_full=0.
- Trigger while already in FILL: the old fill is aborted and restarted from col=0 with the new row, if a fill is required; otherwise state goes to IDLE.
- FILL state:
  - o_rom_req=1, o_rom_row=back_row, o_rom_col=col.
  - Cycle with i_rom_gnt=1: back[col]<=i_rom_val, col++.
  - Cycle with i_rom_gnt=0: hold col, keep requesting; no timeout.
  - Grant on col==MAP_WIDTH-1: capture, back_full<=1, state=IDLE, o_rom_req drops the next cycle.
- Swap: on any cycle with hpos==0 and back_full==1:
  - front<=back, front_row<=back_row, front_valid<=1, back_full<=0.
  - Swap and a trigger cannot coincide, since H_VIEW != 0.
- Late fill: if back_full is 0 at hpos==0, no swap. The fill continues, and the swap happens at the next hpos==0 after completion. It is never applied mid-line.
- Outputs:
  - o_valid = front_valid && front_row==vpos[MAP_SCALE+MAP_HBITS-1:MAP_SCALE] && vpos < (MAP_HEIGHT<<MAP_SCALE). Combinational from registers and vpos.
  - o_map_val = o_valid ? front[i_ovl_col] : 2'b00. Combinational, zero latency.
- Cost: one full fill takes MAP_WIDTH granted cycles; with constant grant, latency is MAP_WIDTH cycles from the trigger to back_full=1.
- o_rom_req is never asserted outside FILL.

Optional Feature:
- Macro: MAP_ROW_CACHE_STATS_EN.
- When defined, adds output o_miss_count (8 bits), a saturating counter:
  - increments on each hpos==0 cycle where in_map(vpos) holds and o_valid would be 0 after that cycle's swap;
  - clears to 0 on reset and on hpos==0 && vpos==0;
  - saturates at 255.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Constant grant, vpos=7, hpos=640 → o_rom_req high for exactly 16 cycles with o_rom_row=1, o_rom_col=0..15. At vpos=8, hpos=0: swap; o_valid=1; i_ovl_col=5 returns the ROM value at (5,1).
- Grant toggled every other cycle from hpos=640 → 32 cycles to fill, contents are correct, no column is skipped or duplicated.
- Grant held low until hpos=0 of vpos=8 → o_valid=0 for all of line 8. Fill completes during line 8, swap at line 9 hpos=0, o_valid=1 (row 1). With MAP_ROW_CACHE_STATS_EN, o_miss_count increments by 1.
- vpos=524, hpos=640 → fill of row 0 starts. vpos=0, hpos=0: swap, o_valid=1. vpos=200, hpos=640 (next_line outside the map) → o_rom_req stays 0.
- reset_n pulsed low mid-FILL at col=9 → o_rom_req=0 immediately (async), o_valid=0, buffers cleared. The next trigger restarts at col=0.
- Line within the same map row (vpos=8→9) with front_row already 1 → no fill at hpos=640, o_rom_req stays 0.
